sampler_ring: RTL and testbench
===============================

Name: sampler_ring

Overview:
Parametrised successor to the single-shot codec sampler. On each go_in it captures one hop of SEG_LEN samples from the Wolfson codec Avalon-ST left/right sources into a segmented ring buffer. It then pulses go_out to first_hannifier with the segment index where the newest full window begins. Source channel is selectable: left, right, or mono mix.

Parameters:
DATA_W, 16, sample width (codec stream width)
ADDR_W, 13, ring buffer address width; depth = 2**ADDR_W
NUM_SEGS, 4, ring segments (power of 2, >=2); SEG_LEN = 2**ADDR_W / NUM_SEGS
CHAN_MODE, 0, 0 = left, 1 = right, 2 = mix (L+R)/2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
go_in  in  1  start capture of one hop
left_in_data  in  DATA_W  codec left sample (signed)
left_in_valid  in  1  left valid
left_in_ready  out  1  left ready
right_in_data  in  DATA_W  codec right sample (signed)
right_in_valid  in  1  right valid
right_in_ready  out  1  right ready
ring_buf_data  out  DATA_W  write data
ring_buf_addr  out  ADDR_W  write address
ring_buf_wren  out  1  write enable
window_start  out  $clog2(NUM_SEGS)  oldest segment of newest window
go_out  out  1  one-cycle pulse: hop written

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset, including mid-capture: all outputs 0, ring_buf_addr = 0, window_start = 0, FSM -> IDLE, in-flight sample dropped, no write.
- FSM: IDLE -> CAPTURE -> FLUSH -> DONE -> IDLE.
- IDLE: both readys low, wren low. go_in=1 -> CAPTURE with sample count cleared. go_in in any other state is ignored.
- CAPTURE, ready rules:
  - Modes 0/1: both readys high. The unselected channel is drained and its samples are discarded.
  - Mode 2: left_in_ready = right_in_ready = left_in_valid & right_in_valid, so both are consumed together.
- Accept condition:
  - Mode 0: left valid & ready.
  - Mode 1: right valid & ready.
  - Mode 2: both valid.
- Mix arithmetic: sign-extend both samples to DATA_W+1 bits, add, arithmetic shift right by 1, truncate to DATA_W. No overflow is possible.
- Write timing:
  - Each accept registers ring_buf_data, ring_buf_addr and ring_buf_wren=1 for exactly one cycle, one cycle after the accept.
  - The address increments after each write and wraps modulo 2**ADDR_W (2**ADDR_W-1 -> 0).
  - Back-to-back accepts produce back-to-back writes.
- On the SEG_LEN-th accept -> FLUSH: readys drop in the same cycle the FSM leaves CAPTURE, and the final write is issued.
- DONE: window_start <= (segment just written + 1) mod NUM_SEGS. go_out=1 for exactly this one cycle, window_start valid with it. Next cycle -> IDLE.
- go_in held high through DONE starts the next hop in the cycle after return to IDLE.
- Capture latency: go_in to go_out = 1 + (cycles to SEG_LEN accepts) + 2.

Optional Feature:
SAMPLER_RING_OVERRUN_EN.
- Defined: adds output overrun (1 bit, reset 0), set sticky when go_in=1 while FSM != IDLE; cleared only by reset.
- Undefined: no port, and busy-state go_in is silently ignored.

Decomposition:
- sampler_pkg:
  - chan_mode_e enum (CHAN_LEFT=0, CHAN_RIGHT=1, CHAN_MIX=2).
  - FSM state enum.
  - Function mix_samples(l, r).
- One sub-module, sampler_addr_gen:
  - Ring write counter with wrap.
  - In-segment count.
  - Segment index.
  - Terminal-count flag.

Test Plan:
- Reset/idle: hold reset 3 cycles with valids high -> all outputs 0, readys low, no wren.
- Mode 0, ADDR_W=4, NUM_SEGS=4: go_in, left data 1..4 continuous -> writes addr 0..3 data 1..4, go_out pulse, window_start=1.
- Wrap: 4 consecutive hops -> 4th hop writes addr 12..15, window_start=0; 5th hop writes addr 0.
- Mode 2: L=16'h7FFF, R=16'h7FFF -> 16'h7FFF; L=16'h8000, R=16'h7FFF -> 16'hFFFF; left valid alone -> no accept, readys low.
- Backpressure: valid toggling 1-0-1 -> wren only after accepts, address contiguous; go_in mid-capture ignored (overrun=1 with macro).
- Reset mid-capture after 2 samples -> next hop restarts at addr 0, window_start=0.

Source files
------------

// File: rtl/sampler_pkg.sv
// Shared types and helpers for the segmented ring sampler.
package sampler_pkg;

  // Which codec channel feeds the ring.
  typedef enum logic [1:0] {
    CHAN_LEFT  = 2'd0,
    CHAN_RIGHT = 2'd1,
    CHAN_MIX   = 2'd2
  } chan_mode_e;

  // Capture sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Working width for the mix; callers sign-extend into it and truncate back.
  // Supports sample widths up to MIX_W-1 bits.
  localparam int MIX_W = 32;

  // (l + r) / 2 with one guard bit, arithmetic shift right by one.
  function automatic logic [MIX_W-1:0] mix_samples(input logic [MIX_W-1:0] l,
                                                  input logic [MIX_W-1:0] r);
    logic [MIX_W:0] sum;
    sum = {l[MIX_W-1], l} + {r[MIX_W-1], r};
    return sum[MIX_W:1];
  endfunction

endpackage

// File: rtl/sampler_addr_gen.sv
// Ring write pointer with natural wrap, in-hop sample count and terminal flag.
module sampler_addr_gen #(
  parameter int ADDR_W  = 13,
  parameter int SEG_W   = 2,
  parameter int CNT_W   = 11,
  parameter int SEG_LEN = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [SEG_W-1:0]  next_seg,
  output logic              last
);

  logic [ADDR_W-1:0] ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // Pointer advances on every accepted sample; count restarts at each hop.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
    end else begin
      if (advance) ptr_reg <= ptr_reg + ADDR_W'(1);
      if (clear) cnt_reg <= '0;
      else if (advance) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign wr_ptr   = ptr_reg;
  // Hops stay segment aligned, so after a hop the pointer sits at the start
  // of the segment following the one just written.
  assign next_seg = ptr_reg[ADDR_W-1 -: SEG_W];
  assign last     = (cnt_reg == CNT_W'(SEG_LEN - 1));

endmodule

// File: rtl/sampler_ring.sv
// Captures one hop of SEG_LEN codec samples per go_in into a segmented ring
// and announces the newest window start with a go_out pulse.
// Optional: define SAMPLER_RING_OVERRUN_EN to add a sticky overrun output.
module sampler_ring
  import sampler_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 13,
  parameter int NUM_SEGS  = 4,
  parameter int CHAN_MODE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        go_in,
  input  logic [DATA_W-1:0]           left_in_data,
  input  logic                        left_in_valid,
  output logic                        left_in_ready,
  input  logic [DATA_W-1:0]           right_in_data,
  input  logic                        right_in_valid,
  output logic                        right_in_ready,
  output logic [DATA_W-1:0]           ring_buf_data,
  output logic [ADDR_W-1:0]           ring_buf_addr,
  output logic                        ring_buf_wren,
  output logic [$clog2(NUM_SEGS)-1:0] window_start,
`ifdef SAMPLER_RING_OVERRUN_EN
  output logic                        overrun,
`endif
  output logic                        go_out
);

  localparam int SEG_W   = $clog2(NUM_SEGS);
  localparam int SEG_LEN = (2 ** ADDR_W) / NUM_SEGS;
  localparam int CNT_W   = (ADDR_W - SEG_W > 0) ? (ADDR_W - SEG_W) : 1;
  localparam chan_mode_e MODE = chan_mode_e'(CHAN_MODE);

  state_e            state_reg, state_next;
  logic              accept;
  logic              hop_start;
  logic              last;
  logic [ADDR_W-1:0] wr_ptr;
  logic [SEG_W-1:0]  next_seg;
  logic [DATA_W-1:0] sample;
  logic [MIX_W-1:0]  left_ext, right_ext;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              wren_reg;
  logic [SEG_W-1:0]  window_reg;

  assign hop_start = (state_reg == ST_IDLE) && go_in;

  sampler_addr_gen #(
    .ADDR_W (ADDR_W),
    .SEG_W  (SEG_W),
    .CNT_W  (CNT_W),
    .SEG_LEN(SEG_LEN)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (hop_start),
    .advance (accept),
    .wr_ptr  (wr_ptr),
    .next_seg(next_seg),
    .last    (last)
  );

  assign left_ext  = {{(MIX_W-DATA_W){left_in_data[DATA_W-1]}}, left_in_data};
  assign right_ext = {{(MIX_W-DATA_W){right_in_data[DATA_W-1]}}, right_in_data};

  // Handshake: single-channel modes drain both sources, mix consumes pairs.
  always_comb begin
    left_in_ready  = 1'b0;
    right_in_ready = 1'b0;
    accept         = 1'b0;
    if (state_reg == ST_CAPTURE) begin
      if (MODE == CHAN_MIX) begin
        left_in_ready  = left_in_valid & right_in_valid;
        right_in_ready = left_in_valid & right_in_valid;
        accept         = left_in_valid & right_in_valid;
      end else begin
        left_in_ready  = 1'b1;
        right_in_ready = 1'b1;
        accept         = (MODE == CHAN_RIGHT) ? right_in_valid : left_in_valid;
      end
    end
  end

  // Select the sample written to the ring.
  always_comb begin
    case (MODE)
      CHAN_RIGHT: sample = right_in_data;
      CHAN_MIX:   sample = DATA_W'(mix_samples(left_ext, right_ext));
      default:    sample = left_in_data;
    endcase
  end

  // Next-state logic for the capture sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (go_in) state_next = ST_CAPTURE;
      ST_CAPTURE: if (accept && last) state_next = ST_FLUSH;
      ST_FLUSH:   state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Registered ring write one cycle after each accept; window latched for DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg   <= '0;
      addr_reg   <= '0;
      wren_reg   <= 1'b0;
      window_reg <= '0;
    end else begin
      wren_reg <= accept;
      if (accept) begin
        data_reg <= sample;
        addr_reg <= wr_ptr;
      end
      if (state_reg == ST_FLUSH) window_reg <= next_seg;
    end
  end

`ifdef SAMPLER_RING_OVERRUN_EN
  logic overrun_reg;

  // Sticky flag: a start request arrived while a hop was still in progress.
  always_ff @(posedge clk) begin
    if (reset) overrun_reg <= 1'b0;
    else if (go_in && (state_reg != ST_IDLE)) overrun_reg <= 1'b1;
  end

  assign overrun = overrun_reg;
`endif

  assign ring_buf_data = data_reg;
  assign ring_buf_addr = addr_reg;
  assign ring_buf_wren = wren_reg;
  assign window_start  = window_reg;
  assign go_out        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_sampler_ring.sv
// Directed bench for sampler_ring: left mode and mix mode instances,
// ADDR_W=4, NUM_SEGS=4 (SEG_LEN=4).
module tb_sampler_ring;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NS = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, go0, go2;
  logic [DW-1:0] ld, rd;
  logic          lv, rv;

  logic          lr0, rr0, wren0, gout0;
  logic [DW-1:0] bd0;
  logic [AW-1:0] ba0;
  logic [SW-1:0] ws0;
  logic          lr2, rr2, wren2, gout2;
  logic [DW-1:0] bd2;
  logic [AW-1:0] ba2;
  logic [SW-1:0] ws2;
`ifdef SAMPLER_RING_OVERRUN_EN
  logic          ov0, ov2;
`endif

  sampler_ring #(.DATA_W(DW), .ADDR_W(AW), .NUM_SEGS(NS), .CHAN_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .go_in(go0),
    .left_in_data(ld), .left_in_valid(lv), .left_in_ready(lr0),
    .right_in_data(rd), .right_in_valid(rv), .right_in_ready(rr0),
    .ring_buf_data(bd0), .ring_buf_addr(ba0), .ring_buf_wren(wren0),
    .window_start(ws0),
`ifdef SAMPLER_RING_OVERRUN_EN
    .overrun(ov0),
`endif
    .go_out(gout0)
  );

  sampler_ring #(.DATA_W(DW), .ADDR_W(AW), .NUM_SEGS(NS), .CHAN_MODE(2)) u_dut2 (
    .clk(clk), .reset(reset), .go_in(go2),
    .left_in_data(ld), .left_in_valid(lv), .left_in_ready(lr2),
    .right_in_data(rd), .right_in_valid(rv), .right_in_ready(rr2),
    .ring_buf_data(bd2), .ring_buf_addr(ba2), .ring_buf_wren(wren2),
    .window_start(ws2),
`ifdef SAMPLER_RING_OVERRUN_EN
    .overrun(ov2),
`endif
    .go_out(gout2)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq0[$], wq2[$];
  logic [SW-1:0] gq0[$], gq2[$];
  int            cyc = 0;
  int            gcyc0 = 0, gcyc2 = 0;
  int            checks = 0, fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every ring write and every go_out pulse.
  always @(negedge clk) begin
    if (wren0) wq0.push_back({ba0, bd0});
    if (wren2) wq2.push_back({ba2, bd2});
    if (gout0) begin gq0.push_back(ws0); gcyc0 = cyc; end
    if (gout2) begin gq2.push_back(ws2); gcyc2 = cyc; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    fails++;
    $display("FAIL %s actual=missing required=present", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nwait();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_go(input int which, output int c0);
    if (which == 0) go0 = 1'b1; else go2 = 1'b1;
    tick();
    go0 = 1'b0;
    go2 = 1'b0;
    c0  = cyc;
  endtask

  // Present one left sample and hold it until the left mode instance takes it.
  task automatic send_l(input logic [DW-1:0] d);
    int n;
    n  = 0;
    lv = 1'b1;
    ld = d;
    nwait();
    while (!lr0 && n < 20) begin nwait(); n++; end
    if (!lr0) miss("left_ready_timeout");
    tick();
  endtask

  task automatic wait_go(input int which, input logic [SW-1:0] exp_ws,
                         input int c0, input int exp_lat);
    int n;
    int sz;
    n  = 0;
    sz = (which == 0) ? gq0.size() : gq2.size();
    while (sz == 0 && n < 20) begin
      nwait();
      n++;
      sz = (which == 0) ? gq0.size() : gq2.size();
    end
    if (sz == 0) miss("go_out_timeout");
    else begin
      if (which == 0) chk("window_start", 32'(gq0.pop_front()), 32'(exp_ws));
      else            chk("window_start_mix", 32'(gq2.pop_front()), 32'(exp_ws));
      if (exp_lat > 0) chk("go_latency", (which == 0 ? gcyc0 : gcyc2) - c0, exp_lat);
      nwait();
      chk("go_out_one_cycle", (which == 0) ? 32'(gout0) : 32'(gout2), 0);
    end
  endtask

  task automatic chk_write(input int which, input string name,
                           input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    wr_t w;
    if ((which == 0) ? (wq0.size() == 0) : (wq2.size() == 0)) miss(name);
    else begin
      w = (which == 0) ? wq0.pop_front() : wq2.pop_front();
      chk({name, "_addr"}, 32'(w.a), 32'(ea));
      chk({name, "_data"}, 32'(w.d), 32'(ed));
    end
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } vec_t;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] ed;
  } mix_t;

  vec_t          tv[20];
  logic [SW-1:0] ws_exp[5];
  mix_t          mv[4];

  initial begin
    int c0;
    // Five hops of data 1..20: addresses 0..15 then wrap to 0..3.
    for (int k = 0; k < 20; k++) begin
      tv[k].din = 16'(k + 1);
      tv[k].ea  = 4'(k % 16);
      tv[k].ed  = 16'(k + 1);
    end
    ws_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    mv[0] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    mv[1] = '{16'h8000, 16'h7FFF, 16'hFFFF};
    mv[2] = '{16'h0001, 16'h0003, 16'h0002};
    mv[3] = '{16'hFFFF, 16'hFFFE, 16'hFFFE};

    // Reset held 3 cycles with valids high.
    reset = 1'b1; go0 = 1'b0; go2 = 1'b0;
    lv = 1'b1; rv = 1'b1; ld = 16'h1234; rd = 16'h4321;
    repeat (3) begin
      nwait();
      chk("rst_left_ready", 32'(lr0), 0);
      chk("rst_right_ready", 32'(rr0), 0);
      chk("rst_wren", 32'(wren0), 0);
      chk("rst_go_out", 32'(gout0), 0);
      chk("rst_addr", 32'(ba0), 0);
      chk("rst_data", 32'(bd0), 0);
      chk("rst_window", 32'(ws0), 0);
      chk("rst_mix_ready", 32'(lr2), 0);
      chk("rst_mix_wren", 32'(wren2), 0);
`ifdef SAMPLER_RING_OVERRUN_EN
      chk("rst_overrun", 32'(ov0), 0);
`endif
    end
    reset = 1'b0;
    nwait();
    chk("idle_left_ready", 32'(lr0), 0);
    chk("idle_right_ready", 32'(rr0), 0);
    chk("idle_mix_ready", 32'(rr2), 0);
    chk("idle_wren", 32'(wren0), 0);
    lv = 1'b0; rv = 1'b0;
    wq0.delete(); wq2.delete(); gq0.delete(); gq2.delete();

    // Five continuous left-mode hops from the table.
    for (int h = 0; h < 5; h++) begin
      pulse_go(0, c0);
      for (int j = 0; j < 4; j++) send_l(tv[h*4+j].din);
      lv = 1'b0;
      wait_go(0, ws_exp[h], c0, 5);
      chk("hop_write_count", wq0.size(), 4);
      for (int j = 0; j < 4; j++) chk_write(0, "hop_write", tv[h*4+j].ea, tv[h*4+j].ed);
      $display("hop %0d left mode done", h);
    end

    // Backpressure: valid 1-0-1-0, plus a go_in while busy.
    wq0.delete();
    pulse_go(0, c0);
    for (int j = 0; j < 4; j++) begin
      lv = 1'b1; ld = 16'h00A0 + 16'(j);
      tick();
      lv = 1'b0;
      if (j == 1) go0 = 1'b1;
      nwait();
      chk("bp_write_after_accept", 32'(wren0), 1);
      if (j == 0) chk("bp_right_drained_ready", 32'(rr0), 1);
      tick();
      go0 = 1'b0;
      nwait();
      chk("bp_no_write_after_gap", 32'(wren0), 0);
    end
    wait_go(0, 2'd2, c0, 0);
    chk("bp_write_count", wq0.size(), 4);
    for (int j = 0; j < 4; j++) chk_write(0, "bp_write", 4'(4 + j), 16'h00A0 + 16'(j));
`ifdef SAMPLER_RING_OVERRUN_EN
    chk("overrun_sticky", 32'(ov0), 1);
`endif
    $display("backpressure hop done");

    // Reset mid-capture after two accepts; the third sample is dropped.
    pulse_go(0, c0);
    lv = 1'b1; ld = 16'h0055; tick();
    ld = 16'h0056; tick();
    ld = 16'h0057; reset = 1'b1; tick();
    reset = 1'b0; lv = 1'b0;
    nwait();
    chk("midrst_wren", 32'(wren0), 0);
    chk("midrst_addr", 32'(ba0), 0);
    chk("midrst_window", 32'(ws0), 0);
    chk("midrst_ready", 32'(lr0), 0);
`ifdef SAMPLER_RING_OVERRUN_EN
    chk("midrst_overrun", 32'(ov0), 0);
`endif
    wq0.delete(); gq0.delete();
    pulse_go(0, c0);
    for (int j = 0; j < 4; j++) send_l(16'h0061 + 16'(j));
    lv = 1'b0;
    wait_go(0, 2'd1, c0, 5);
    for (int j = 0; j < 4; j++) chk_write(0, "postrst_write", 4'(j), 16'h0061 + 16'(j));
    $display("mid-capture reset hop done");

    // Mix mode: left alone is not accepted, then four paired samples.
    wq2.delete(); gq2.delete();
    pulse_go(2, c0);
    lv = 1'b1; rv = 1'b0; ld = 16'h1111; rd = 16'h2222;
    nwait();
    chk("mix_left_only_lready", 32'(lr2), 0);
    chk("mix_left_only_rready", 32'(rr2), 0);
    tick();
    nwait();
    chk("mix_left_only_no_write", 32'(wren2), 0);
    for (int j = 0; j < 4; j++) begin
      lv = 1'b1; rv = 1'b1; ld = mv[j].l; rd = mv[j].r;
      tick();
    end
    lv = 1'b0; rv = 1'b0;
    wait_go(2, 2'd1, c0, 0);
    chk("mix_write_count", wq2.size(), 4);
    for (int j = 0; j < 4; j++) chk_write(2, "mix_write", 4'(j), mv[j].ed);
    $display("mix hop done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
